// File: rtl/subleq_mem_if.sv
// Memory, loader and output-port signals between subleq_mem and its environment.
// The slave modport is the memory side; the master modport is the core/loader side.
interface subleq_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] i_raddr;
  logic [DATA_W-1:0] o_rdata;
  logic [ADDR_W-1:0] i_waddr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_we;
  logic              o_cpu_rstn;
  logic              i_load_req;
  logic              i_run;
  logic              i_ld_valid;
  logic [DATA_W-1:0] i_ld_data;
  logic              i_ld_last;
  logic              o_ld_ready;
  logic [ADDR_W:0]   o_ld_count;
  logic              o_busy;
  logic [DATA_W-1:0] o_out;
  logic              o_out_stb;

  modport slave (
    input  i_raddr, i_waddr, i_wdata, i_we, i_load_req, i_run,
           i_ld_valid, i_ld_data, i_ld_last,
    output o_rdata, o_cpu_rstn, o_ld_ready, o_ld_count, o_busy, o_out, o_out_stb
  );

  modport master (
    output i_raddr, i_waddr, i_wdata, i_we, i_load_req, i_run,
           i_ld_valid, i_ld_data, i_ld_last,
    input  o_rdata, o_cpu_rstn, o_ld_ready, o_ld_count, o_busy, o_out, o_out_stb
  );
endinterface

// File: rtl/subleq_mem.sv
// Subleq memory responder with byte-stream program loader that holds the core in reset.
// Define SUBLEQ_MEM_MMIO_EN to enable the output port at MMIO_ADDR.
module subleq_mem #(
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 8,
  parameter logic [ADDR_W-1:0] MMIO_ADDR = 8'hFF
) (
  input logic        i_clk,
  input logic        i_rstn,
  subleq_mem_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

`ifdef SUBLEQ_MEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   ld_count;
  logic              cpu_rstn;
  logic              ld_ready;
  logic              busy;
  logic [DATA_W-1:0] out_q;
  logic              out_stb;

  logic ld_fire;
  logic ld_end;
  logic core_we;
  logic mmio_hit;

  // The load pointer is the low bits of the byte count; both clear together.
  assign ld_fire  = (state == LOAD) && ld_ready && bus.i_ld_valid;
  assign ld_end   = ld_fire && (bus.i_ld_last || (ld_count == (ADDR_W+1)'(DEPTH - 1)));
  assign core_we  = (state == RUN) && bus.i_we;
  assign mmio_hit = core_we && (bus.i_waddr == MMIO_ADDR);

  // NOTE: the array has no reset so it can map onto RAM; contents survive rst_n.
  always_ff @(posedge i_clk) begin
    if (ld_fire)
      mem[ld_count[ADDR_W-1:0]] <= bus.i_ld_data;
    else if (core_we)
      mem[bus.i_waddr] <= bus.i_wdata;
  end

  assign bus.o_rdata = mem[bus.i_raddr];

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      cpu_rstn <= 1'b0;
      ld_ready <= 1'b0;
      ld_count <= '0;
      busy     <= 1'b0;
      out_q    <= '0;
      out_stb  <= 1'b0;
    end else begin
      out_stb <= MMIO_EN && mmio_hit;
      if (MMIO_EN && mmio_hit)
        out_q <= bus.i_wdata;

      unique case (state)
        IDLE: begin
          if (bus.i_load_req) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
            ld_count <= '0;
          end else if (bus.i_run) begin
            state <= RELEASE;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          // A restart discards the count even if a byte lands in the same cycle.
          if (bus.i_load_req) begin
            ld_count <= '0;
          end else if (ld_fire) begin
            ld_count <= ld_count + 1'b1;
            if (ld_end) begin
              state    <= RELEASE;
              ld_ready <= 1'b0;
            end
          end
        end
        RELEASE: begin
          state    <= RUN;
          busy     <= 1'b0;
          cpu_rstn <= 1'b1;
        end
        RUN: begin
          if (bus.i_load_req) begin
            state    <= LOAD;
            cpu_rstn <= 1'b0;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
            ld_count <= '0;
          end
        end
      endcase
    end
  end

  assign bus.o_cpu_rstn = cpu_rstn;
  assign bus.o_ld_ready = ld_ready;
  assign bus.o_ld_count = ld_count;
  assign bus.o_busy     = busy;
  assign bus.o_out      = out_q;
  assign bus.o_out_stb  = out_stb;
endmodule

// File: tb/tb_subleq_mem.sv
// Scoreboard bench for subleq_mem: stimulus pushes expectations, a negedge monitor pops and compares.
// Honours SUBLEQ_MEM_MMIO_EN to expect the output-port behaviour.
module tb_subleq_mem;
  logic clk;
  logic rst_n;

  subleq_mem_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  subleq_mem #(.ADDR_W(8), .DATA_W(8), .MMIO_ADDR(8'hFF)) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rstn;
    bit         ready;
    bit         busy;
    logic [8:0] count;
    bit         chk_rd;
    logic [7:0] rd;
    logic [7:0] out;
    bit         stb;
  } exp_t;

  exp_t exp_q [$];
  int   acc_q [$];
  int   total = 0;
  int   bad   = 0;
  int   probe_n = 0;
  bit   probe_en = 1'b0;

  // Reference model: memory image, loader pointer/count, output port.
  logic [7:0] m_mem [256];
  int         m_ptr   = 0;
  int         m_count = 0;
  logic [7:0] m_out   = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares status on probe cycles and load pointer on every accepted byte.
  always @(negedge clk) begin
    if (probe_en) begin
      if (exp_q.size() == 0) begin
        check("probe_queue_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("p%0d_cpu_rstn", probe_n), 32'(bus.o_cpu_rstn), 32'(e.rstn));
        check($sformatf("p%0d_ld_ready", probe_n), 32'(bus.o_ld_ready), 32'(e.ready));
        check($sformatf("p%0d_busy", probe_n),     32'(bus.o_busy),     32'(e.busy));
        check($sformatf("p%0d_ld_count", probe_n), 32'(bus.o_ld_count), 32'(e.count));
        check($sformatf("p%0d_out", probe_n),      32'(bus.o_out),      32'(e.out));
        check($sformatf("p%0d_out_stb", probe_n),  32'(bus.o_out_stb),  32'(e.stb));
        if (e.chk_rd)
          check($sformatf("p%0d_rdata@%0h", probe_n, bus.i_raddr), 32'(bus.o_rdata), 32'(e.rd));
      end
      probe_n++;
    end
    if (bus.i_ld_valid && bus.o_ld_ready) begin
      if (acc_q.size() == 0)
        check("unexpected_accept", 32'd1, 32'd0);
      else
        check("ld_ptr_at_accept", 32'(bus.o_ld_count), 32'(acc_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input bit rstn, input bit ready, input bit busy,
                       input bit chk_rd, input logic [7:0] addr, input bit stb);
    exp_t e;
    e.rstn   = rstn;
    e.ready  = ready;
    e.busy   = busy;
    e.count  = 9'(m_count);
    e.chk_rd = chk_rd;
    e.rd     = m_mem[addr];
    e.out    = m_out;
    e.stb    = stb;
    exp_q.push_back(e);
    bus.i_raddr = addr;
    probe_en    = 1'b1;
    tick();
    probe_en    = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    bus.i_ld_valid = 1'b1;
    bus.i_ld_data  = d;
    bus.i_ld_last  = last;
    acc_q.push_back(m_ptr);
    m_mem[8'(m_ptr)] = d;
    m_ptr++;
    m_count = m_ptr;
    tick();
  endtask

  task automatic ld_idle();
    bus.i_ld_valid = 1'b0;
    bus.i_ld_last  = 1'b0;
  endtask

  task automatic gap();
    ld_idle();
    tick();
  endtask

  task automatic start_load();
    bus.i_load_req = 1'b1;
    tick();
    bus.i_load_req = 1'b0;
    m_ptr   = 0;
    m_count = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    bit         stb_exp;

    rst_n          = 1'b0;
    bus.i_raddr    = '0;
    bus.i_waddr    = '0;
    bus.i_wdata    = '0;
    bus.i_we       = 1'b0;
    bus.i_load_req = 1'b0;
    bus.i_run      = 1'b0;
    bus.i_ld_valid = 1'b0;
    bus.i_ld_data  = '0;
    bus.i_ld_last  = 1'b0;

    // Reset, then ten idle cycles.
    repeat (2) tick();
    probe(0, 0, 0, 0, 8'h00, 0);
    rst_n = 1'b1;
    repeat (10) probe(0, 0, 0, 0, 8'h00, 0);

    // Simultaneous load_req and run: load wins.
    bus.i_load_req = 1'b1;
    bus.i_run      = 1'b1;
    tick();
    bus.i_load_req = 1'b0;
    bus.i_run      = 1'b0;
    m_ptr = 0;
    m_count = 0;
    probe(0, 1, 1, 0, 8'h00, 0);

    // Basic load: 07 07 03, last on the third.
    send(8'h07, 0);
    send(8'h07, 0);
    send(8'h03, 1);
    ld_idle();
    probe(0, 0, 1, 0, 8'h00, 0);
    probe(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) probe(1, 0, 0, 1, 8'(i), 0);

    // Full-depth load with random valid gaps; a trailing valid byte must not be taken.
    start_load();
    probe(0, 1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 1) == 1) gap();
      send(8'(i), 0);
    end
    bus.i_ld_data = 8'hEE;
    probe(0, 0, 1, 0, 8'h00, 0);
    ld_idle();
    probe(1, 0, 0, 1, 8'h00, 0);
    probe(1, 0, 0, 1, 8'h80, 0);
    probe(1, 0, 0, 1, 8'hFF, 0);

    // Run-time write: same-cycle read is old data, next cycle is new.
    bus.i_we    = 1'b1;
    bus.i_waddr = 8'h10;
    bus.i_wdata = 8'hA5;
    probe(1, 0, 0, 1, 8'h10, 0);
    bus.i_we = 1'b0;
    m_mem[8'h10] = 8'hA5;
    probe(1, 0, 0, 1, 8'h10, 0);

    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 254));
      d = 8'($urandom);
      bus.i_we    = 1'b1;
      bus.i_waddr = a;
      bus.i_wdata = d;
      tick();
      bus.i_we = 1'b0;
      m_mem[a] = d;
      probe(1, 0, 0, 1, a, 0);
    end

    // Output-port write at 0xFF.
    bus.i_we    = 1'b1;
    bus.i_waddr = 8'hFF;
    bus.i_wdata = 8'h42;
    probe(1, 0, 0, 1, 8'hFF, 0);
    bus.i_we = 1'b0;
    m_mem[8'hFF] = 8'h42;
`ifdef SUBLEQ_MEM_MMIO_EN
    m_out   = 8'h42;
    stb_exp = 1'b1;
`else
    stb_exp = 1'b0;
`endif
    probe(1, 0, 0, 1, 8'hFF, stb_exp);
    probe(1, 0, 0, 1, 8'hFF, 0);

    // Load with valid toggling; core write on the RUN->LOAD edge lands, later ones are ignored.
    bus.i_we    = 1'b1;
    bus.i_waddr = 8'h10;
    bus.i_wdata = 8'h5A;
    start_load();
    m_mem[8'h10] = 8'h5A;
    bus.i_wdata  = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      gap();
      send(8'($urandom), k == 3);
    end
    ld_idle();
    probe(0, 0, 1, 0, 8'h00, 0);
    bus.i_we = 1'b0;
    probe(1, 0, 0, 1, 8'h10, 0);
    for (int i = 0; i < 4; i++) probe(1, 0, 0, 1, 8'(i), 0);

    // Restart mid-load: the byte in the restart cycle is written but not counted.
    start_load();
    send(8'($urandom), 0);
    send(8'($urandom), 0);
    d = 8'($urandom);
    bus.i_load_req = 1'b1;
    bus.i_ld_valid = 1'b1;
    bus.i_ld_data  = d;
    bus.i_ld_last  = 1'b0;
    acc_q.push_back(m_ptr);
    m_mem[8'(m_ptr)] = d;
    m_ptr   = 0;
    m_count = 0;
    tick();
    bus.i_load_req = 1'b0;
    send(8'($urandom), 0);
    send(8'($urandom), 1);
    ld_idle();
    probe(0, 0, 1, 0, 8'h00, 0);
    probe(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) probe(1, 0, 0, 1, 8'(i), 0);

    // Async reset mid-load, then release straight from IDLE with run.
    start_load();
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);
    ld_idle();
    rst_n   = 1'b0;
    m_count = 0;
    m_out   = 8'h00;
    probe(0, 0, 0, 0, 8'h00, 0);
    rst_n = 1'b1;
    probe(0, 0, 0, 0, 8'h00, 0);
    bus.i_run = 1'b1;
    tick();
    bus.i_run = 1'b0;
    probe(0, 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) probe(1, 0, 0, 1, 8'(i), 0);

    tick();
    check("probe_queue_drained",  32'(exp_q.size()), 32'd0);
    check("accept_queue_drained", 32'(acc_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
